// File: rtl/audio_sched_pkg.sv
// Shared types, constants and helpers for the audio tone scheduler.
package audio_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StPlay  = 2'd2
  } state_e;

  localparam logic [31:0] AmplitudeDefault = 32'h0FFFFFF0;

  // Widest request vector the priority encoder handles.
  localparam int unsigned MaxReq = 32;

  // Index of the lowest set bit (highest priority); 0 when no bit is set.
  function automatic logic [4:0] lowest_set(input logic [MaxReq-1:0] vec);
    lowest_set = '0;
    for (int i = MaxReq - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = 5'(i);
    end
  endfunction

endpackage

// File: rtl/audio_tone_scheduler_if.sv
// Audio_Controller sample handshake and data, shared between scheduler and codec side.
interface audio_tone_scheduler_if;

  logic        audio_in_available;
  logic        audio_out_allowed;
  logic [31:0] left_channel_audio_in;
  logic [31:0] right_channel_audio_in;
  logic        read_audio_in;
  logic        write_audio_out;
  logic [31:0] left_channel_audio_out;
  logic [31:0] right_channel_audio_out;

  // Scheduler side: consumes line-in, produces mixed samples and strobes.
  modport master (
    input  audio_in_available,
    input  audio_out_allowed,
    input  left_channel_audio_in,
    input  right_channel_audio_in,
    output read_audio_in,
    output write_audio_out,
    output left_channel_audio_out,
    output right_channel_audio_out
  );

  // Audio_Controller side.
  modport slave (
    output audio_in_available,
    output audio_out_allowed,
    output left_channel_audio_in,
    output right_channel_audio_in,
    input  read_audio_in,
    input  write_audio_out,
    input  left_channel_audio_out,
    input  right_channel_audio_out
  );

endinterface

// File: rtl/square_tone_gen.sv
// Square-wave generator: counts CLOCK_50 cycles against a half-period and flips polarity.
module square_tone_gen
  import audio_sched_pkg::*;
#(
  parameter int unsigned PERIOD_W  = 19,
  parameter logic [31:0] AMPLITUDE = AmplitudeDefault
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                en_i,
  input  logic [PERIOD_W-1:0] half_period_i,
  output logic [31:0]         tone_o
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                phase_q, phase_d;

  // Load restarts on the positive half; a zero half-period (rest) freezes the counter.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (load_i) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (en_i && (half_period_i != '0)) begin
      if (cnt_q == half_period_i) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + PERIOD_W'(1);
      end
    end
  end

  // Counter and phase state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign tone_o = phase_q ? AMPLITUDE : (~AMPLITUDE + 32'd1);

endmodule

// File: rtl/audio_tone_scheduler.sv
// Arbitrates tone requesters by fixed priority, plays the granted square tone for a
// sample-counted duration and mixes it onto the line-in passthrough.
module audio_tone_scheduler
  import audio_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned PERIOD_W  = 19,
  parameter int unsigned DUR_W     = 16,
  parameter logic [31:0] AMPLITUDE = AmplitudeDefault,
  parameter bit          PREEMPT   = 1'b1,
  localparam int unsigned IdW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*PERIOD_W-1:0] req_half_period,
  input  logic [NUM_REQ*DUR_W-1:0]    req_duration,
  output logic [NUM_REQ-1:0]          ack,
  output logic                        busy,
  output logic [IdW-1:0]              active_id,
  input  logic                        mute,
  audio_tone_scheduler_if.master      audio
);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                busy_q, busy_d;
  logic [IdW-1:0]      active_id_q, active_id_d;
  logic [PERIOD_W-1:0] half_period_q, half_period_d;
  logic [DUR_W-1:0]    dur_q, dur_d;

  logic               xfer;
  logic               grant_en;
  logic [IdW-1:0]     grant_id;
  logic [NUM_REQ-1:0] higher_mask;
  logic [NUM_REQ-1:0] preempt_req;
  logic               play_tone;
  logic [31:0]        tone;
  logic [31:0]        tone_mix;

  // A sample moves in both directions whenever the codec is ready on both sides.
  assign xfer                  = audio.audio_in_available & audio.audio_out_allowed & ~reset;
  assign audio.read_audio_in   = xfer;
  assign audio.write_audio_out = xfer;

  // Requesters strictly higher in priority than the one currently holding the output.
  always_comb begin
    higher_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      higher_mask[i] = (i < int'(active_id_q));
    end
    preempt_req = PREEMPT ? (req & higher_mask) : '0;
  end

  // Arbitration, FSM next state and duration bookkeeping.
  always_comb begin
    state_d       = state_q;
    ack_d         = '0;
    active_id_d   = active_id_q;
    half_period_d = half_period_q;
    dur_d         = dur_q;
    grant_en      = 1'b0;
    grant_id      = '0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          grant_en = 1'b1;
          grant_id = IdW'(lowest_set(MaxReq'(req)));
        end
      end
      StGrant: begin
        state_d = (dur_q != '0) ? StPlay : StIdle;
      end
      StPlay: begin
        if (xfer) begin
          dur_d = dur_q - DUR_W'(1);
          if (dur_q == DUR_W'(1)) state_d = StIdle;
        end
        // Pre-emption overrides completion in the same cycle.
        if (|preempt_req) begin
          grant_en = 1'b1;
          grant_id = IdW'(lowest_set(MaxReq'(preempt_req)));
        end
      end
      default: state_d = StIdle;
    endcase
    if (grant_en) begin
      state_d         = StGrant;
      ack_d[grant_id] = 1'b1;
      active_id_d     = grant_id;
      half_period_d   = req_half_period[grant_id*PERIOD_W +: PERIOD_W];
      dur_d           = req_duration[grant_id*DUR_W +: DUR_W];
    end
  end

  assign busy_d = (state_d != StIdle);

  // FSM and registered outputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      ack_q         <= '0;
      busy_q        <= 1'b0;
      active_id_q   <= '0;
      half_period_q <= '0;
      dur_q         <= '0;
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      busy_q        <= busy_d;
      active_id_q   <= active_id_d;
      half_period_q <= half_period_d;
      dur_q         <= dur_d;
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign active_id = active_id_q;

  square_tone_gen #(
    .PERIOD_W (PERIOD_W),
    .AMPLITUDE(AMPLITUDE)
  ) u_tone (
    .clk_i        (CLOCK_50),
    .rst_i        (reset),
    .load_i       (grant_en),
    .en_i         (state_q == StPlay),
    .half_period_i(half_period_q),
    .tone_o       (tone)
  );

  // Tone is added only while playing an audible, unmuted note; sums wrap.
  always_comb begin
    play_tone = (state_q == StPlay) && !mute && (half_period_q != '0);
    tone_mix  = play_tone ? tone : 32'd0;
  end

  assign audio.left_channel_audio_out  = audio.left_channel_audio_in + tone_mix;
  assign audio.right_channel_audio_out = audio.right_channel_audio_in + tone_mix;

endmodule

// File: tb/tb_audio_tone_scheduler.sv
// Self-checking bench: directed scenarios plus randomized requesters against a tone-level model.
module tb_audio_tone_scheduler;

  localparam int NumReq  = 4;
  localparam int PeriodW = 19;
  localparam int DurW    = 16;
  localparam logic [31:0] Amp = 32'h0FFFFFF0;

  localparam int MIdle  = 0;
  localparam int MGrant = 1;
  localparam int MPlay  = 2;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [NumReq-1:0]          req = '0;
  logic [NumReq*PeriodW-1:0]  hp_bus = '0;
  logic [NumReq*DurW-1:0]     dur_bus = '0;
  logic [NumReq-1:0]          ack;
  logic                       busy;
  logic [1:0]                 active_id;
  logic                       mute = 1'b0;

  int r_hp  [NumReq];
  int r_dur [NumReq];

  audio_tone_scheduler_if aif ();

  audio_tone_scheduler #(
    .NUM_REQ  (NumReq),
    .PERIOD_W (PeriodW),
    .DUR_W    (DurW),
    .AMPLITUDE(Amp),
    .PREEMPT  (1'b1)
  ) dut (
    .CLOCK_50       (clk),
    .reset          (rst),
    .req            (req),
    .req_half_period(hp_bus),
    .req_duration   (dur_bus),
    .ack            (ack),
    .busy           (busy),
    .active_id      (active_id),
    .mute           (mute),
    .audio          (aif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Tone-level model: which requester owns the output, samples left, cycles into the tone.
  int                m_mode;
  int                m_id;
  int                m_hp;
  int                m_left;
  int                m_pc;
  logic [NumReq-1:0] m_ack;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int first_set(input logic [NumReq-1:0] v);
    for (int i = 0; i < NumReq; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic xfer_now();
    return aif.audio_in_available && aif.audio_out_allowed && !rst;
  endfunction

  task automatic model_reset();
    m_mode = MIdle;
    m_id   = 0;
    m_hp   = 0;
    m_left = 0;
    m_pc   = 0;
    m_ack  = '0;
  endtask

  task automatic model_grant(input int k);
    m_mode   = MGrant;
    m_ack    = '0;
    m_ack[k] = 1'b1;
    m_id     = k;
    m_hp     = r_hp[k];
    m_left   = r_dur[k];
    m_pc     = 0;
  endtask

  task automatic model_step();
    int k;
    logic [NumReq-1:0] hi;
    if (rst) begin
      model_reset();
      return;
    end
    m_ack = '0;
    case (m_mode)
      MIdle: begin
        k = first_set(req);
        if (k >= 0) model_grant(k);
      end
      MGrant: m_mode = (m_left != 0) ? MPlay : MIdle;
      default: begin
        m_pc++;
        if (xfer_now()) begin
          m_left--;
          if (m_left == 0) m_mode = MIdle;
        end
        hi = '0;
        for (int j = 0; j < m_id; j++) hi[j] = req[j];
        k = first_set(hi);
        if (k >= 0) model_grant(k);
      end
    endcase
  endtask

  task automatic check_outputs();
    logic [31:0] tone_e;
    logic        xf;
    xf     = xfer_now();
    tone_e = '0;
    // Tone starts positive and flips every (half_period + 1) cycles of play.
    if (m_mode == MPlay && !mute && m_hp != 0)
      tone_e = (((m_pc / (m_hp + 1)) % 2) == 0) ? Amp : (32'd0 - Amp);
    check_eq("read_audio_in", aif.read_audio_in, xf);
    check_eq("write_audio_out", aif.write_audio_out, xf);
    check_eq("ack", ack, m_ack);
    check_eq("busy", busy, (m_mode != MIdle));
    check_eq("active_id", active_id, m_id);
    check_eq("left_out", aif.left_channel_audio_out, aif.left_channel_audio_in + tone_e);
    check_eq("right_out", aif.right_channel_audio_out, aif.right_channel_audio_in + tone_e);
  endtask

  // One clock: requesters drop on their ack, outputs checked, model advanced at the edge.
  task automatic tick();
    for (int i = 0; i < NumReq; i++) if (m_ack[i]) req[i] = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      hp_bus[i*PeriodW +: PeriodW] = PeriodW'(r_hp[i]);
      dur_bus[i*DurW +: DurW]      = DurW'(r_dur[i]);
    end
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic run_until_idle(input int max);
    int n;
    n = 0;
    tick();
    while (m_mode != MIdle && n < max) begin
      tick();
      n++;
    end
    #1;
    check_eq("busy_after_tone", busy, 1'b0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aif.audio_in_available     = 1'b1;
    aif.audio_out_allowed      = 1'b1;
    aif.left_channel_audio_in  = 32'h00001000;
    aif.right_channel_audio_in = 32'h00002000;
    for (int i = 0; i < NumReq; i++) begin
      r_hp[i]  = 0;
      r_dur[i] = 0;
    end
    model_reset();
    @(negedge clk);

    // Reset held: strobes and status quiet.
    tick();
    tick();
    #1;
    check_eq("rst_write", aif.write_audio_out, 1'b0);
    check_eq("rst_ack", ack, 4'b0000);
    check_eq("rst_busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    check_eq("rel_write", aif.write_audio_out, 1'b1);
    check_eq("rel_left", aif.left_channel_audio_out, 32'h00001000);

    // Single tone on requester 2.
    r_hp[2]  = 4;
    r_dur[2] = 3;
    req      = 4'b0100;
    tick();
    #1;
    check_eq("single_ack", ack, 4'b0100);
    tick();
    #1;
    check_eq("single_first_play", aif.left_channel_audio_out, 32'h00001000 + Amp);
    run_until_idle(20);

    // Simultaneous requests served in priority order.
    r_hp[1] = 1; r_dur[1] = 2;
    r_hp[3] = 3; r_dur[3] = 2;
    req     = 4'b1010;
    tick();
    #1;
    check_eq("simul_first_ack", ack, 4'b0010);
    run_until_idle(20);
    tick();
    #1;
    check_eq("simul_second_ack", ack, 4'b1000);
    run_until_idle(20);

    // Pre-emption of a long tone on requester 3 by requester 0.
    r_hp[3] = 4; r_dur[3] = 100;
    req[3]  = 1'b1;
    tick();
    tick();
    repeat (10) tick();
    r_hp[0] = 2; r_dur[0] = 2;
    req[0]  = 1'b1;
    tick();
    #1;
    check_eq("preempt_ack", ack, 4'b0001);
    check_eq("preempt_id", active_id, 2'd0);
    run_until_idle(20);
    tick();
    tick();
    #1;
    check_eq("preempt_no_reack", ack, 4'b0000);

    // Wrap-around on the mix.
    aif.left_channel_audio_in = 32'hFFFFFFF0;
    r_hp[1] = 50; r_dur[1] = 3;
    req[1]  = 1'b1;
    tick();
    tick();
    #1;
    check_eq("wrap_left", aif.left_channel_audio_out, 32'h0FFFFFE0);
    run_until_idle(20);
    aif.left_channel_audio_in = 32'h00001000;

    // Rest and muted tone still consume their duration.
    r_hp[2] = 0; r_dur[2] = 5;
    req[2]  = 1'b1;
    run_until_idle(20);
    mute    = 1'b1;
    r_hp[2] = 3; r_dur[2] = 6;
    req[2]  = 1'b1;
    run_until_idle(20);
    mute    = 1'b0;

    // Zero duration: ack but no play.
    r_hp[0] = 3; r_dur[0] = 0;
    req[0]  = 1'b1;
    tick();
    #1;
    check_eq("zero_dur_ack", ack, 4'b0001);
    tick();
    #1;
    check_eq("zero_dur_idle", busy, 1'b0);

    // Reset in the middle of a tone.
    r_hp[3] = 2; r_dur[3] = 40;
    req[3]  = 1'b1;
    tick();
    tick();
    repeat (5) tick();
    rst = 1'b1;
    model_reset();
    #1;
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_ack", ack, 4'b0000);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    #1;
    check_eq("midrst_after_busy", busy, 1'b0);

    // Randomized requesters, codec readiness, mute, samples and occasional resets.
    repeat (4000) begin
      aif.audio_in_available     = ($urandom_range(0, 3) != 0);
      aif.audio_out_allowed      = ($urandom_range(0, 3) != 0);
      mute                       = ($urandom_range(0, 7) == 0);
      aif.left_channel_audio_in  = $urandom;
      aif.right_channel_audio_in = $urandom;
      for (int i = 0; i < NumReq; i++) begin
        if (!req[i] && !m_ack[i] && $urandom_range(0, 15) == 0) begin
          r_hp[i]  = $urandom_range(0, 6);
          r_dur[i] = $urandom_range(0, 12);
          req[i]   = 1'b1;
        end
      end
      rst = ($urandom_range(0, 399) == 0);
      if (rst) model_reset();
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_tone_scheduler.md
Name: audio_tone_scheduler

Overview:
- Sits between the game/sound-effect logic and Audio_Controller; shares the single audio output among NUM_REQ tone requesters.
- Grants by fixed priority, with optional pre-emption, and plays the granted square-wave tone for a sample-counted duration.
- Mixes the tone onto the line-in passthrough and drives the Audio_Controller read/write handshake.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 has the highest priority.
- PERIOD_W, 19, width of the half-period in CLOCK_50 cycles.
- DUR_W, 16, width of the duration in accepted output samples.
- AMPLITUDE, 32'h0FFFFFF0, tone magnitude; the tone is +AMPLITUDE or -AMPLITUDE.
- PREEMPT, 1, if 1 a strictly higher-priority request aborts the current tone.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  request level per requester; held until its ack.
- req_half_period  in  NUM_REQ*PERIOD_W  packed half-period per requester; 0 means a rest (silence).
- req_duration  in  NUM_REQ*DUR_W  packed duration per requester.
- ack  out  NUM_REQ  one-cycle one-hot grant pulse.
- busy  out  1  high while in GRANT or PLAY.
- active_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- mute  in  1  suppresses the tone; duration still counts.
- audio_in_available  in  1  from Audio_Controller.
- audio_out_allowed  in  1  from Audio_Controller.
- left_channel_audio_in  in  32  line-in sample, left channel.
- right_channel_audio_in  in  32  line-in sample, right channel.
- read_audio_in  out  1  to Audio_Controller.
- write_audio_out  out  1  to Audio_Controller.
- left_channel_audio_out  out  32  mixed output sample, left channel.
- right_channel_audio_out  out  32  mixed output sample, right channel.

Behaviour:
- Reset:
  - All registers clear asynchronously: state=IDLE, ack=0, busy=0, active_id=0, phase=0, period counter=0, duration counter=0, latched half-period=0.
  - read_audio_in and write_audio_out are forced 0 while reset is high.
- Handshake:
  - xfer = audio_in_available & audio_out_allowed & ~reset.
  - read_audio_in = write_audio_out = xfer, combinational with zero latency.
- Mixing:
  - tone = phase ? AMPLITUDE : -AMPLITUDE.
  - When state=PLAY, mute=0 and latched half-period!=0: out = in + tone per channel, 32-bit two's-complement wrap with no saturation.
  - In every other case out = in (pure passthrough).
- FSM, IDLE:
  - If any req bit is set, select the lowest set index k and go to GRANT.
- FSM, GRANT (exactly 1 cycle):
  - ack[k]=1.
  - Latch active_id=k, req_half_period slice k and req_duration slice k.
  - Clear the period counter; set phase=1.
  - Next state: PLAY if the latched duration!=0, else IDLE. A zero duration still gets its ack but plays 0 samples.
- FSM, PLAY:
  - Period counter increments every cycle. When it equals the latched half-period it wraps to 0 and phase toggles.
  - With half-period 0 the counter stays 0 and the output is silent.
  - Each xfer cycle decrements the duration counter. If xfer occurs with the counter at 1, the next state is IDLE.
  - If PREEMPT=1 and req[j] is set for some j<active_id, go to GRANT for the lowest such j. This takes precedence over completion in the same cycle. The aborted requester receives no second ack.
- Pending requests:
  - A requester that is not granted keeps req high and is served in priority order after the current tone.
  - No request queue beyond the req levels themselves.
- ack:
  - Registered; high only during GRANT; never more than one bit set.
- busy = (state != IDLE).
- active_id holds its value after returning to IDLE.
- req re-asserted by the requester whose tone is playing, while in PLAY: ignored until IDLE, or pre-empts if it has a higher index than nothing (i.e. never pre-empts itself).
- Reset mid-tone: the tone stops immediately; the output reverts to passthrough of the inputs once reset is released.

Decomposition:
- Package audio_sched_pkg holds:
  - state encoding (IDLE, GRANT, PLAY);
  - the AMPLITUDE default;
  - a function for the priority-encode lowest index.
- One natural sub-module, square_tone_gen: period counter, phase register, load and enable inputs; outputs the signed tone.
- Arbitration, FSM, duration counter and mixing stay in the top.

Test Plan:
- Reset-held passthrough:
  - Stimulus: reset=1 with audio_in_available=audio_out_allowed=1; then release reset with left_in=32'h00001000.
  - Required: during reset write_audio_out=0, ack=0, busy=0. After release, left_out=32'h00001000 and write_audio_out=1.
- Single tone:
  - Stimulus: req[2] with half_period=4, duration=3; xfer high every cycle.
  - Required: ack=4'b0100 for one cycle. Phase toggles every 5 cycles. left_out=in+32'h0FFFFFF0 at the first PLAY cycle. busy drops after exactly 3 xfer cycles in PLAY.
- Simultaneous requests:
  - Stimulus: req=4'b1010 in IDLE.
  - Required: ack=4'b0010 first; ack=4'b1000 one cycle after the first tone completes.
- Pre-emption:
  - Stimulus: PREEMPT=1, req[3] playing with duration=100; after 10 xfers assert req[0] with duration=2.
  - Required: ack[0] pulses on the next cycle; active_id=0; exactly 2 samples played; then IDLE with no ack[3].
- Rest, mute and wrap:
  - half_period=0 with duration=5: output equals input for 5 xfers, then IDLE.
  - mute=1: output equals input while duration still counts.
  - in=32'hFFFFFFF0 with tone +AMPLITUDE: out=32'h0FFFFFE0 (wrap).
- Zero duration and reset mid-tone:
  - duration=0: ack pulses, then IDLE with no tone.
  - reset asserted during PLAY: busy=0 and ack=0 immediately; no ack after release unless req is still high.
